// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice.
// Optional feature macro: MEM_RESP_ALIGN_CHECK_EN (misaligned-access detection).
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10,
    HOLD = 2'b11
  } state_t;

  localparam logic [1:0] MS_BYTE  = 2'b00;
  localparam logic [1:0] MS_HALF  = 2'b01;
  localparam logic [1:0] MS_WORD  = 2'b10;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Size code 2'b11 behaves as a word, so anything above a halfword checks 4-byte alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MS_BYTE: return 1'b0;
      MS_HALF: return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_resp_extend.sv
// Read-path size select and sign/zero extension.
// Input raw holds four big-endian bytes starting at the access base address.
module mem_resp_extend (
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);
  import mem_responder_pkg::*;

  always_comb begin
    data = raw;
    case (size)
      MS_BYTE: data = {{24{sign_ext & raw[31]}}, raw[31:24]};
      MS_HALF: data = {{16{sign_ext & raw[31]}}, raw[31:16]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Handshaked byte-array memory responder with programmable wait states, big-endian access.
// Optional feature macro: MEM_RESP_ALIGN_CHECK_EN (flags and suppresses misaligned accesses).
module mem_responder #(
  parameter int WAIT_STATES = 2,
  parameter int MEM_DEPTH   = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MOV,
  input  logic        RW,
  input  logic [2:0]  MS,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        ALIGN_ERR
);
  import mem_responder_pkg::*;

  localparam int AW = $clog2(MEM_DEPTH);

  logic [7:0] memory [MEM_DEPTH];

  state_t         state;
  logic [3:0]     cnt;
  logic           rw_q;
  logic [2:0]     ms_q;
  logic [AW-1:0]  addr_q;
  logic [31:0]    din_q;

  logic [AW-1:0]  a1, a2, a3;
  logic [31:0]    raw, ext_data;
  logic           access, misaligned, do_write;
  logic           unused_addr;

  // Index arithmetic at AW bits gives the wrap past MEM_DEPTH-1 for free.
  assign a1 = addr_q + AW'(1);
  assign a2 = addr_q + AW'(2);
  assign a3 = addr_q + AW'(3);
  assign raw = {memory[addr_q], memory[a1], memory[a2], memory[a3]};
  assign unused_addr = ^Address[31:AW];

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(ms_q[1:0], addr_q[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign access   = (state == WAIT) && MOV && (cnt == 4'd0);
  assign do_write = access && (rw_q == RW_WRITE) && !misaligned && !RESET;

  mem_resp_extend u_extend (
    .raw      (raw),
    .size     (ms_q[1:0]),
    .sign_ext (ms_q[2]),
    .data     (ext_data)
  );

  always_ff @(posedge CLK) begin
    if (do_write) begin
      case (ms_q[1:0])
        MS_BYTE: memory[addr_q] <= din_q[7:0];
        MS_HALF: begin
          memory[addr_q] <= din_q[15:8];
          memory[a1]     <= din_q[7:0];
        end
        default: begin
          memory[addr_q] <= din_q[31:24];
          memory[a1]     <= din_q[23:16];
          memory[a2]     <= din_q[15:8];
          memory[a3]     <= din_q[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      MOC       <= 1'b0;
      DataOut   <= 32'd0;
      ALIGN_ERR <= 1'b0;
      rw_q      <= RW_READ;
      ms_q      <= 3'd0;
      addr_q    <= '0;
      din_q     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (MOV) begin
            rw_q   <= RW;
            ms_q   <= MS;
            addr_q <= Address[AW-1:0];
            din_q  <= DataIn;
            cnt    <= 4'(WAIT_STATES);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (!MOV) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state     <= DONE;
            ALIGN_ERR <= misaligned;
            if (misaligned)
              DataOut <= 32'd0;
            else if (rw_q == RW_READ)
              DataOut <= ext_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          MOC   <= 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          if (!MOV) begin
            MOC       <= 1'b0;
            ALIGN_ERR <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, sets the number of idle cycles between request capture and MOC assertion (legal 0..15).
REQ-002 Parameter MEM_DEPTH, default 256, sets the number of byte locations; it SHALL be a power of two.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 MOV  input  1  request; the initiator holds it high until it sees MOC.
REQ-006 RW  input  1  0 = read, 1 = write.
REQ-007 MS  input  3  MS[1:0] size (00 byte, 01 halfword, 10 word, 11 word); MS[2] = 1 sign-extends reads.
REQ-008 Address  input  32  byte address; only the low log2(MEM_DEPTH) bits are decoded.
REQ-009 DataIn  input  32  write data, right-justified.
REQ-010 DataOut  output  32  read data, right-justified and extended.
REQ-011 MOC  output  1  memory operation complete.
REQ-012 ALIGN_ERR  output  1  misaligned request flag (only when MEM_RESP_ALIGN_CHECK_EN is defined; otherwise tied 0).

Function
REQ-013 States SHALL be IDLE, WAIT, DONE and HOLD, encoded in a 2-bit state register.
REQ-014 IDLE->WAIT on MOV=1: capture RW, MS, Address and DataIn into internal registers and load the wait counter with WAIT_STATES.
REQ-015 In WAIT, decrement the counter each cycle; at 0 (or immediately if WAIT_STATES=0), perform the access and go to DONE.
REQ-016 In DONE, assert MOC and go to HOLD; in HOLD, keep MOC=1 until MOV=0, then MOC=0 on the next edge and return to IDLE.
REQ-017 Latency SHALL be MOC high exactly WAIT_STATES+2 rising edges after the edge that samples MOV=1.
REQ-018 Access order SHALL be big-endian: the byte at the base address goes to the most significant byte of the sized field.
REQ-019 A read SHALL update DataOut at the DONE transition; DataOut holds its value until the next read completes.
REQ-020 Unsigned reads zero-extend; signed reads replicate the top bit of the sized field into bits 31 up to the field width.
REQ-021 A write SHALL update exactly 1, 2 or 4 bytes from DataIn[7:0], [15:0] or [31:0].
REQ-022 Multi-byte accesses crossing MEM_DEPTH-1 wrap to location 0.
REQ-023 MOV dropping in WAIT aborts the access: no write, DataOut unchanged, MOC stays 0, return to IDLE.
REQ-024 Input changes after capture SHALL be ignored; a new request requires MOV to return low first.
REQ-025 The byte array SHALL be named memory and remain hierarchically writable for bench preload.

Reset
REQ-026 RESET=1 immediately forces state IDLE, MOC=0, DataOut=0, ALIGN_ERR=0 and the wait counter to 0.
REQ-027 Reset mid-operation SHALL abort without writing; memory contents are not cleared by reset.

Configuration
REQ-028 With MEM_RESP_ALIGN_CHECK_EN defined, a halfword at an odd address or a word at a non-multiple-of-4 address SHALL suppress the write, return DataOut=0, still complete the handshake, and hold ALIGN_ERR=1 from DONE until IDLE.
REQ-029 Without MEM_RESP_ALIGN_CHECK_EN, misaligned accesses proceed with wrap rules and ALIGN_ERR is constant 0.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the MS size codes (MS_BYTE, MS_HALF, MS_WORD) and the RW_READ/RW_WRITE constants.
REQ-031 One sub-module, mem_resp_extend, SHALL be the combinational size-select and sign/zero-extend unit used on the read path.

Verification
REQ-032 Byte preload at memory[4..7] = 8'h81, 8'h22, 8'h33, 8'h44; word read at address 4 -> DataOut=32'h81223344, MOC high 4 edges after MOV (WAIT_STATES=2).
REQ-033 Signed byte read at address 4 (MS=3'b100) -> 32'hFFFFFF81; unsigned (MS=3'b000) -> 32'h00000081.
REQ-034 Halfword write of 32'h0000BEEF at address 10, then unsigned halfword read -> memory[10]=8'hBE, memory[11]=8'hEF, DataOut=32'h0000BEEF.
REQ-035 Word write of 32'hA1B2C3D4 at address 254 -> memory[254]=8'hA1, memory[255]=8'hB2, memory[0]=8'hC3, memory[1]=8'hD4 (macro undefined).
REQ-036 MOV dropped one cycle into WAIT on a write, and RESET asserted during WAIT on another -> memory unchanged, MOC never asserted, state IDLE.
REQ-037 With MEM_RESP_ALIGN_CHECK_EN, word write at address 2 -> memory unchanged, ALIGN_ERR=1 while MOC=1, handshake completes normally.
